maple_rx_frame_checker: RTL and testbench

- Sits directly downstream of the receiver and in front of the RX FIFO on the AXI-Stream byte path.
- Parses each Maple frame: a 4-byte header, then N data words (4 bytes each), then a 1-byte XOR checksum.
- Forwards the header and data bytes, strips the checksum, and flags bad frames on the last beat via tuser.
- Counts good and bad frames for the control register block.

---
 rtl/maple_rx_frame_checker.sv | 194 +++++++++++++++++++
 tb/tb_maple_rx_frame_checker.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maple_rx_frame_checker.sv
// maple_rx_frame_checker
//   Receives the Maple byte stream, parses each frame, and passes it on toward the RX FIFO.
//   A frame is a 4-byte header (data word count N in byte LEN_BYTE_IDX), then 4N data
//   bytes, then a 1-byte XOR checksum. The checker forwards the header and data bytes,
//   strips the checksum, and marks a bad frame with tuser on its last forwarded beat.
//   It also keeps saturating counts of good and bad frames.
//
// Ports
//   aclk, aresetn            clock, asynchronous active-low reset
//   enable                   when low, no input bytes are accepted
//   clear_counts             one-cycle pulse that zeroes frames_ok/frames_err
//   s_axis_*                 byte stream from the receiver (tdata/tlast/tvalid/tready)
//   m_axis_*                 byte stream to the RX FIFO (tuser = error, valid with tlast)
//   frame_done               one-cycle pulse per completed frame
//   frame_err_code           0 OK, 1 CSUM, 2 SHORT, 3 LONG; held until the next frame_done
//   frames_ok, frames_err    saturating frame counters
module maple_rx_frame_checker #(
  parameter int LEN_BYTE_IDX = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 enable,
  input  logic                 clear_counts,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 frame_done,
  output logic [1:0]           frame_err_code,
  output logic [CNT_WIDTH-1:0] frames_ok,
  output logic [CNT_WIDTH-1:0] frames_err
);
  localparam int DATA_W = 8;
  localparam logic [10:0] LEN_IDX = 11'(LEN_BYTE_IDX);
  localparam logic [1:0] CODE_OK    = 2'd0;
  localparam logic [1:0] CODE_CSUM  = 2'd1;
  localparam logic [1:0] CODE_SHORT = 2'd2;
  localparam logic [1:0] CODE_LONG  = 2'd3;

  typedef enum logic [1:0] {ST_HDR, ST_DATA, ST_CSUM, ST_DRAIN} state_t;

  state_t            state, state_nxt;
  logic [10:0]       byte_cnt, byte_cnt_nxt;
  logic [7:0]        n_words;
  logic [7:0]        n_eff;
  logic [10:0]       data_end;
  logic [DATA_W-1:0] xor_acc;

  logic [DATA_W-1:0] data_p0;
  logic              vld_p0;
  logic              short_p0;
  logic [DATA_W-1:0] data_p1;
  logic              vld_p1;
  logic              last_p1;
  logic              user_p1;

  logic              can_load;
  logic              acc;
  logic              acc_fwd;
  logic              acc_csum;
  logic              hold_mv;
  logic              csum_bad;
  logic              done_nxt;
  logic [1:0]        code_nxt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign can_load      = !vld_p1 || m_axis_tready;
  assign s_axis_tready = aresetn && enable && (!vld_p0 || can_load);
  assign acc           = s_axis_tvalid && s_axis_tready;
  assign acc_fwd       = acc && (state == ST_HDR || state == ST_DATA);
  assign acc_csum      = acc && (state == ST_CSUM);
  // A held byte leaves when the next frame byte arrives (which decides its tlast/tuser),
  // or on its own when it is the tlast byte of a short frame.
  assign hold_mv       = vld_p0 && can_load && (acc_fwd || acc_csum || short_p0);
  assign csum_bad      = !s_axis_tlast || (s_axis_tdata != xor_acc);
  assign done_nxt      = hold_mv && (short_p0 || acc_csum);
  assign code_nxt      = short_p0                    ? CODE_SHORT :
                         !s_axis_tlast               ? CODE_LONG  :
                         (s_axis_tdata != xor_acc)   ? CODE_CSUM  : CODE_OK;

  // The count byte may be the final header byte itself, so take it straight from the bus.
  assign n_eff    = (state == ST_HDR && byte_cnt == LEN_IDX) ? s_axis_tdata : n_words;
  assign data_end = {1'b0, n_words, 2'b00} + 11'd3;

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    if (acc) begin
      unique case (state)
        ST_HDR: begin
          if (s_axis_tlast) begin
            byte_cnt_nxt = 11'd0;
          end else if (byte_cnt == 11'd3) begin
            byte_cnt_nxt = 11'd4;
            state_nxt    = (n_eff == 8'd0) ? ST_CSUM : ST_DATA;
          end else begin
            byte_cnt_nxt = byte_cnt + 11'd1;
          end
        end
        ST_DATA: begin
          if (s_axis_tlast) begin
            byte_cnt_nxt = 11'd0;
            state_nxt    = ST_HDR;
          end else begin
            byte_cnt_nxt = byte_cnt + 11'd1;
            if (byte_cnt == data_end) state_nxt = ST_CSUM;
          end
        end
        ST_CSUM: begin
          byte_cnt_nxt = 11'd0;
          state_nxt    = s_axis_tlast ? ST_HDR : ST_DRAIN;
        end
        ST_DRAIN: begin
          if (s_axis_tlast) state_nxt = ST_HDR;
        end
      endcase
    end
  end

  // Stage 0: holding register, parse state and running checksum
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= ST_HDR;
      byte_cnt <= 11'd0;
      xor_acc  <= '0;
      vld_p0   <= 1'b0;
      short_p0 <= 1'b0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      if (acc_fwd) begin
        xor_acc  <= (state == ST_HDR && byte_cnt == 11'd0) ? s_axis_tdata : (xor_acc ^ s_axis_tdata);
        vld_p0   <= 1'b1;
        short_p0 <= s_axis_tlast;
      end else if (hold_mv) begin
        vld_p0   <= 1'b0;
        short_p0 <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (acc_fwd) begin
      data_p0 <= s_axis_tdata;
      if (state == ST_HDR && byte_cnt == LEN_IDX) n_words <= s_axis_tdata;
    end
  end

  // Stage 1: output register, frame status and counters
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_p1         <= 1'b0;
      data_p1        <= '0;
      last_p1        <= 1'b0;
      user_p1        <= 1'b0;
      frame_done     <= 1'b0;
      frame_err_code <= CODE_OK;
      frames_ok      <= '0;
      frames_err     <= '0;
    end else begin
      if (can_load) begin
        vld_p1 <= hold_mv;
        if (hold_mv) begin
          data_p1 <= data_p0;
          last_p1 <= short_p0 || acc_csum;
          user_p1 <= short_p0 || (acc_csum && csum_bad);
        end
      end
      frame_done <= done_nxt;
      if (done_nxt) frame_err_code <= code_nxt;
      if (clear_counts) begin
        frames_ok  <= '0;
        frames_err <= '0;
      end else if (done_nxt) begin
        if (code_nxt == CODE_OK) frames_ok  <= sat_inc(frames_ok);
        else                     frames_err <= sat_inc(frames_err);
      end
    end
  end

  assign m_axis_tvalid = vld_p1;
  assign m_axis_tdata  = data_p1;
  assign m_axis_tlast  = last_p1;
  assign m_axis_tuser  = user_p1;
endmodule

// File: tb/tb_maple_rx_frame_checker.sv
// Testbench for maple_rx_frame_checker: drives byte bursts, models expected output per
// burst from the frame rules, and compares forwarded beats, result codes and counters.
// A second instance with 4-bit counters shares the stimulus for saturation checks.
module tb_maple_rx_frame_checker;
  localparam int LEN_IDX = 3;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b0;
  logic        clear_counts = 1'b0;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tlast = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        m_tready = 1'b1;
  logic        s_tready, m_tlast, m_tuser, m_tvalid, frame_done;
  logic [7:0]  m_tdata;
  logic [1:0]  code;
  logic [15:0] ok16, err16;
  logic        s_tready4, m_tlast4, m_tuser4, m_tvalid4, frame_done4;
  logic [7:0]  m_tdata4;
  logic [1:0]  code4;
  logic [3:0]  ok4, err4;

  maple_rx_frame_checker #(.LEN_BYTE_IDX(LEN_IDX), .CNT_WIDTH(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .clear_counts(clear_counts),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .frame_done(frame_done), .frame_err_code(code), .frames_ok(ok16), .frames_err(err16));

  maple_rx_frame_checker #(.LEN_BYTE_IDX(LEN_IDX), .CNT_WIDTH(4)) dut_sat (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .clear_counts(clear_counts),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready4), .m_axis_tdata(m_tdata4), .m_axis_tlast(m_tlast4),
    .m_axis_tuser(m_tuser4), .m_axis_tvalid(m_tvalid4), .m_axis_tready(m_tready),
    .frame_done(frame_done4), .frame_err_code(code4), .frames_ok(ok4), .frames_err(err4));

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;
  bit rdy_rand = 1'b0;
  bit en_rand = 1'b0;
  bit en_on = 1'b0;

  always @(posedge aclk) begin
    #1;
    m_tready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    enable   = en_rand ? ($urandom_range(0, 3) != 0) : en_on;
  end

  // observed stream: {tuser, tlast, tdata} per transfer; codes per frame_done
  logic [9:0] got_q[$];
  logic [1:0] gcode_q[$];
  logic       stall_prev = 1'b0;
  logic [9:0] stall_val = '0;
  int         stall_viol = 0;

  always @(negedge aclk) begin
    if (!aresetn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && (!m_tvalid || {m_tuser, m_tlast, m_tdata} !== stall_val)) stall_viol++;
      if (m_tvalid && m_tready) got_q.push_back({m_tuser, m_tlast, m_tdata});
      if (frame_done) gcode_q.push_back(code);
      stall_prev = m_tvalid && !m_tready;
      stall_val  = {m_tuser, m_tlast, m_tdata};
    end
  end

  // expected stream and model counters
  logic [8:0] stim_q[$];
  logic [9:0] exp_q[$];
  logic [1:0] ecode_q[$];
  int exp_ok = 0, exp_err = 0, exp_ok4 = 0, exp_err4 = 0;
  int skew = 0, cskew = 0;

  task automatic add_byte(input logic [7:0] d, input bit l);
    stim_q.push_back({l, d});
  endtask

  task automatic add_frame(input int n, input int kind);
    logic [7:0] b[$];
    logic [7:0] x;
    int cut, extra;
    x = 8'h00;
    for (int i = 0; i < 4 + 4 * n; i++) b.push_back(8'($urandom));
    b[LEN_IDX] = 8'(n);
    foreach (b[i]) x ^= b[i];
    case (kind)
      0: begin foreach (b[i]) add_byte(b[i], 1'b0); add_byte(x, 1'b1); end
      1: begin foreach (b[i]) add_byte(b[i], 1'b0); add_byte(x ^ 8'(1 << $urandom_range(0, 7)), 1'b1); end
      2: begin
        cut = $urandom_range(1, b.size());
        for (int i = 0; i < cut; i++) add_byte(b[i], i == cut - 1);
      end
      default: begin
        foreach (b[i]) add_byte(b[i], 1'b0);
        add_byte(x, 1'b0);
        extra = $urandom_range(1, 3);
        for (int k = 0; k < extra; k++) add_byte(8'($urandom), k == extra - 1);
      end
    endcase
  endtask

  // One burst (bytes up to tlast) judged purely by its length against 4+4N+1.
  task automatic model_burst(input logic [7:0] b[$]);
    int len, tot, fwd;
    logic [7:0] x;
    logic [1:0] c;
    len = b.size();
    tot = (len >= 4) ? 5 + 4 * int'(b[LEN_IDX]) : 1 << 20;
    if (len < tot) begin
      fwd = len;
      c = 2'd2;
    end else begin
      fwd = tot - 1;
      x = 8'h00;
      for (int j = 0; j < fwd; j++) x ^= b[j];
      c = (len > tot) ? 2'd3 : (x != b[tot - 1]) ? 2'd1 : 2'd0;
    end
    for (int j = 0; j < fwd; j++)
      exp_q.push_back({((c != 2'd0) && (j == fwd - 1)), (j == fwd - 1), b[j]});
    ecode_q.push_back(c);
    if (c == 2'd0) begin
      if (exp_ok < 65535) exp_ok++;
      if (exp_ok4 < 15) exp_ok4++;
    end else begin
      if (exp_err < 65535) exp_err++;
      if (exp_err4 < 15) exp_err4++;
    end
  endtask

  task automatic model_stream(input bit clr);
    logic [7:0] b[$];
    for (int i = 0; i < stim_q.size(); i++) begin
      b.push_back(stim_q[i][7:0]);
      if (stim_q[i][8]) begin
        model_burst(b);
        b.delete();
      end
    end
    if (clr) begin
      exp_ok = 0; exp_err = 0; exp_ok4 = 0; exp_err4 = 0;
    end
  endtask

  task automatic drive_stream(input bit clr_last);
    int guard;
    for (int i = 0; i < stim_q.size(); i++) begin
      s_tvalid = 1'b1;
      s_tdata  = stim_q[i][7:0];
      s_tlast  = stim_q[i][8];
      clear_counts = clr_last && (i == stim_q.size() - 1);
      guard = 0;
      @(negedge aclk);
      while (!s_tready && guard < 1000) begin
        @(negedge aclk);
        guard++;
      end
      total++;
      if (!s_tready) begin
        bad++;
        $display("FAIL input_accept byte%0d tready=%b required=1", i, s_tready);
        break;
      end
      @(posedge aclk); #1;
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    clear_counts = 1'b0;
  endtask

  task automatic run_stim(input bit clr);
    model_stream(clr);
    drive_stream(clr);
    stim_q.delete();
    for (int k = 0; k < 3000 && got_q.size() - skew < exp_q.size(); k++) begin
      @(posedge aclk); #1;
    end
    repeat (4) begin @(posedge aclk); #1; end
  endtask

  task automatic test_reset();
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", m_tvalid); end
    total++; if ({m_tuser, m_tlast, m_tdata} !== 10'd0) begin bad++; $display("FAIL reset_beat got=%h want=0", {m_tuser, m_tlast, m_tdata}); end
    total++; if (frame_done !== 1'b0 || code !== 2'd0) begin bad++; $display("FAIL reset_status got=%b/%0d want=0/0", frame_done, code); end
    total++; if (ok16 !== 16'd0 || err16 !== 16'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d want=0/0", ok16, err16); end
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL reset_tready got=%b want=0", s_tready); end
    aresetn = 1'b1;
    en_on = 1'b1;
    repeat (2) begin @(posedge aclk); #1; end
    total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL idle_tready got=%b want=1", s_tready); end
  endtask

  task automatic test_n0();
    int eb = exp_q.size(), cb = ecode_q.size();
    add_byte(8'h01, 0); add_byte(8'h20, 0); add_byte(8'h00, 0); add_byte(8'h00, 0); add_byte(8'h21, 1);
    run_stim(0);
    total++; if (got_q.size() - skew !== exp_q.size()) begin bad++; $display("FAIL n0_beats got=%0d want=%0d", got_q.size() - skew, exp_q.size()); end
    for (int i = eb; i < exp_q.size() && i + skew < got_q.size(); i++) begin
      total++; if (got_q[i + skew] !== exp_q[i]) begin bad++; $display("FAIL n0_beat%0d got=%h want=%h", i - eb, got_q[i + skew], exp_q[i]); end
    end
    total++; if (gcode_q.size() - cskew !== ecode_q.size()) begin bad++; $display("FAIL n0_done_count got=%0d want=%0d", gcode_q.size() - cskew, ecode_q.size()); end
    for (int i = cb; i < ecode_q.size() && i + cskew < gcode_q.size(); i++) begin
      total++; if (gcode_q[i + cskew] !== ecode_q[i]) begin bad++; $display("FAIL n0_code got=%0d want=%0d", gcode_q[i + cskew], ecode_q[i]); end
    end
    total++; if (ok16 !== 16'(exp_ok) || err16 !== 16'(exp_err)) begin bad++; $display("FAIL n0_counts got=%0d/%0d want=%0d/%0d", ok16, err16, exp_ok, exp_err); end
  endtask

  task automatic test_n1_csum();
    int eb = exp_q.size(), cb = ecode_q.size();
    logic [7:0] hdr[8];
    logic [7:0] cs;
    hdr = '{8'h09, 8'h20, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    cs = 8'h00;
    foreach (hdr[i]) cs ^= hdr[i];
    foreach (hdr[i]) add_byte(hdr[i], 0);
    add_byte(cs, 1);
    foreach (hdr[i]) add_byte(hdr[i], 0);
    add_byte(cs ^ 8'h01, 1);
    run_stim(0);
    total++; if (got_q.size() - skew !== exp_q.size()) begin bad++; $display("FAIL n1_beats got=%0d want=%0d", got_q.size() - skew, exp_q.size()); end
    for (int i = eb; i < exp_q.size() && i + skew < got_q.size(); i++) begin
      total++; if (got_q[i + skew] !== exp_q[i]) begin bad++; $display("FAIL n1_beat%0d got=%h want=%h", i - eb, got_q[i + skew], exp_q[i]); end
    end
    for (int i = cb; i < ecode_q.size(); i++) begin
      total++;
      if (i + cskew >= gcode_q.size()) begin bad++; $display("FAIL n1_code missing want=%0d", ecode_q[i]); end
      else if (gcode_q[i + cskew] !== ecode_q[i]) begin bad++; $display("FAIL n1_code got=%0d want=%0d", gcode_q[i + cskew], ecode_q[i]); end
    end
    total++; if (ok16 !== 16'(exp_ok) || err16 !== 16'(exp_err)) begin bad++; $display("FAIL n1_counts got=%0d/%0d want=%0d/%0d", ok16, err16, exp_ok, exp_err); end
  endtask

  task automatic test_short();
    int eb = exp_q.size(), cb = ecode_q.size();
    add_byte(8'h09, 0); add_byte(8'h20, 0); add_byte(8'h00, 0); add_byte(8'h02, 0); add_byte(8'hAA, 1);
    add_byte(8'h01, 0); add_byte(8'h20, 0); add_byte(8'h00, 0); add_byte(8'h00, 0); add_byte(8'h21, 1);
    add_byte(8'h5A, 1);
    run_stim(0);
    total++; if (got_q.size() - skew !== exp_q.size()) begin bad++; $display("FAIL short_beats got=%0d want=%0d", got_q.size() - skew, exp_q.size()); end
    for (int i = eb; i < exp_q.size() && i + skew < got_q.size(); i++) begin
      total++; if (got_q[i + skew] !== exp_q[i]) begin bad++; $display("FAIL short_beat%0d got=%h want=%h", i - eb, got_q[i + skew], exp_q[i]); end
    end
    for (int i = cb; i < ecode_q.size(); i++) begin
      total++;
      if (i + cskew >= gcode_q.size()) begin bad++; $display("FAIL short_code missing want=%0d", ecode_q[i]); end
      else if (gcode_q[i + cskew] !== ecode_q[i]) begin bad++; $display("FAIL short_code got=%0d want=%0d", gcode_q[i + cskew], ecode_q[i]); end
    end
  endtask

  task automatic test_long();
    int eb = exp_q.size(), cb = ecode_q.size();
    add_byte(8'h01, 0); add_byte(8'h20, 0); add_byte(8'h00, 0); add_byte(8'h00, 0); add_byte(8'h21, 0);
    add_byte(8'h55, 0); add_byte(8'h66, 1);
    add_byte(8'h01, 0); add_byte(8'h20, 0); add_byte(8'h00, 0); add_byte(8'h00, 0); add_byte(8'h21, 1);
    run_stim(0);
    total++; if (got_q.size() - skew !== exp_q.size()) begin bad++; $display("FAIL long_beats got=%0d want=%0d", got_q.size() - skew, exp_q.size()); end
    for (int i = eb; i < exp_q.size() && i + skew < got_q.size(); i++) begin
      total++; if (got_q[i + skew] !== exp_q[i]) begin bad++; $display("FAIL long_beat%0d got=%h want=%h", i - eb, got_q[i + skew], exp_q[i]); end
    end
    for (int i = cb; i < ecode_q.size(); i++) begin
      total++;
      if (i + cskew >= gcode_q.size()) begin bad++; $display("FAIL long_code missing want=%0d", ecode_q[i]); end
      else if (gcode_q[i + cskew] !== ecode_q[i]) begin bad++; $display("FAIL long_code got=%0d want=%0d", gcode_q[i + cskew], ecode_q[i]); end
    end
    total++; if (ok16 !== 16'(exp_ok) || err16 !== 16'(exp_err)) begin bad++; $display("FAIL long_counts got=%0d/%0d want=%0d/%0d", ok16, err16, exp_ok, exp_err); end
  endtask

  task automatic test_back_to_back();
    int eb = exp_q.size();
    logic [15:0] ok_start = ok16;
    for (int f = 0; f < 20; f++) add_frame(3, 0);
    rdy_rand = 1'b1;
    run_stim(0);
    rdy_rand = 1'b0;
    repeat (4) begin @(posedge aclk); #1; end
    total++; if (got_q.size() - skew !== exp_q.size()) begin bad++; $display("FAIL b2b_beats got=%0d want=%0d", got_q.size() - skew, exp_q.size()); end
    for (int i = eb; i < exp_q.size() && i + skew < got_q.size(); i++) begin
      total++; if (got_q[i + skew] !== exp_q[i]) begin bad++; $display("FAIL b2b_beat%0d got=%h want=%h", i - eb, got_q[i + skew], exp_q[i]); end
    end
    total++; if (ok16 !== ok_start + 16'd20) begin bad++; $display("FAIL b2b_frames_ok got=%0d want=%0d", ok16, ok_start + 16'd20); end
  endtask

  task automatic test_reset_mid();
    int eb, cb;
    add_byte(8'h11, 0); add_byte(8'h22, 0); add_byte(8'h33, 0); add_byte(8'h03, 0);
    for (int i = 0; i < 5; i++) add_byte(8'($urandom), 0);
    drive_stream(0);
    stim_q.delete();
    #2;
    aresetn = 1'b0;
    #1;
    total++; if (m_tvalid !== 1'b0 || {m_tuser, m_tlast, m_tdata} !== 10'd0) begin bad++; $display("FAIL rstmid_out got=%b/%h want=0/0", m_tvalid, {m_tuser, m_tlast, m_tdata}); end
    total++; if (frame_done !== 1'b0 || code !== 2'd0 || ok16 !== 16'd0 || err16 !== 16'd0) begin bad++; $display("FAIL rstmid_status got=%b/%0d/%0d/%0d want=0/0/0/0", frame_done, code, ok16, err16); end
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL rstmid_tready got=%b want=0", s_tready); end
    total++; if ({m_tvalid4, m_tuser4, m_tlast4, m_tdata4, frame_done4, code4, ok4, err4, s_tready4} !== 23'd0) begin bad++; $display("FAIL rstmid_sat_outputs got=%h want=0", {m_tvalid4, m_tuser4, m_tlast4, m_tdata4, frame_done4, code4, ok4, err4, s_tready4}); end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    skew = got_q.size() - exp_q.size();
    cskew = gcode_q.size() - ecode_q.size();
    exp_ok = 0; exp_err = 0; exp_ok4 = 0; exp_err4 = 0;
    eb = exp_q.size();
    cb = ecode_q.size();
    add_frame(3, 0);
    run_stim(0);
    total++; if (got_q.size() - skew !== exp_q.size()) begin bad++; $display("FAIL rstmid_beats got=%0d want=%0d", got_q.size() - skew, exp_q.size()); end
    for (int i = eb; i < exp_q.size() && i + skew < got_q.size(); i++) begin
      total++; if (got_q[i + skew] !== exp_q[i]) begin bad++; $display("FAIL rstmid_beat%0d got=%h want=%h", i - eb, got_q[i + skew], exp_q[i]); end
    end
    total++; if (gcode_q.size() - cskew !== cb + 1 || ok16 !== 16'd1) begin bad++; $display("FAIL rstmid_frame got_done=%0d ok=%0d want_done=%0d ok=1", gcode_q.size() - cskew, ok16, cb + 1); end
  endtask

  task automatic test_saturation();
    for (int f = 0; f < 20; f++) add_frame($urandom_range(0, 1), 1);
    run_stim(0);
    total++; if (err4 !== 4'd15) begin bad++; $display("FAIL sat_err4 got=%0d want=15", err4); end
    total++; if (err4 !== 4'(exp_err4) || ok4 !== 4'(exp_ok4)) begin bad++; $display("FAIL sat_model4 got=%0d/%0d want=%0d/%0d", ok4, err4, exp_ok4, exp_err4); end
    total++; if (err16 !== 16'(exp_err)) begin bad++; $display("FAIL sat_err16 got=%0d want=%0d", err16, exp_err); end
    add_frame(0, 1);
    run_stim(1);
    total++; if (err4 !== 4'd0 || ok4 !== 4'd0) begin bad++; $display("FAIL clear_prio4 got=%0d/%0d want=0/0", ok4, err4); end
    total++; if (err16 !== 16'd0 || ok16 !== 16'd0) begin bad++; $display("FAIL clear_prio16 got=%0d/%0d want=0/0", ok16, err16); end
    total++; if (code !== 2'd1) begin bad++; $display("FAIL clear_code got=%0d want=1", code); end
  endtask

  task automatic test_random_mix();
    int eb = exp_q.size(), cb = ecode_q.size();
    for (int f = 0; f < 40; f++) add_frame($urandom_range(0, 3), $urandom_range(0, 3));
    rdy_rand = 1'b1;
    en_rand = 1'b1;
    run_stim(0);
    rdy_rand = 1'b0;
    en_rand = 1'b0;
    repeat (4) begin @(posedge aclk); #1; end
    total++; if (got_q.size() - skew !== exp_q.size()) begin bad++; $display("FAIL mix_beats got=%0d want=%0d", got_q.size() - skew, exp_q.size()); end
    for (int i = eb; i < exp_q.size() && i + skew < got_q.size(); i++) begin
      total++; if (got_q[i + skew] !== exp_q[i]) begin bad++; $display("FAIL mix_beat%0d got=%h want=%h", i - eb, got_q[i + skew], exp_q[i]); end
    end
    for (int i = cb; i < ecode_q.size(); i++) begin
      total++;
      if (i + cskew >= gcode_q.size()) begin bad++; $display("FAIL mix_code missing want=%0d", ecode_q[i]); end
      else if (gcode_q[i + cskew] !== ecode_q[i]) begin bad++; $display("FAIL mix_code%0d got=%0d want=%0d", i - cb, gcode_q[i + cskew], ecode_q[i]); end
    end
    total++; if (ok16 !== 16'(exp_ok) || err16 !== 16'(exp_err)) begin bad++; $display("FAIL mix_counts got=%0d/%0d want=%0d/%0d", ok16, err16, exp_ok, exp_err); end
    total++; if (ok4 !== 4'(exp_ok4) || err4 !== 4'(exp_err4)) begin bad++; $display("FAIL mix_counts4 got=%0d/%0d want=%0d/%0d", ok4, err4, exp_ok4, exp_err4); end
    total++; if (stall_viol !== 0) begin bad++; $display("FAIL stall_stability got=%0d changes want=0", stall_viol); end
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    test_reset();
    test_n0();
    test_n1_csum();
    test_short();
    test_long();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    test_random_mix();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
